// File: rtl/sch_addr_pkg.sv
// Shared definitions for the scheduler address generator.
//   state_t      : tile sequencing states (IDLE, RUN, DONE)
//   STATE_W      : encoded state width
//   stride_scale : multiplies a row offset by the stride (1 or 2) with a shift
package sch_addr_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Stride is 1 or 2, so scaling is either a pass-through or a left shift.
    function automatic logic [31:0] stride_scale(input logic [31:0] v, input logic stride2);
        return stride2 ? {v[30:0], 1'b0} : v;
    endfunction

endpackage

// File: rtl/sch_loop_cnt.sv
// Wrapping loop counter used to build the kx/ky/channel/row-group loop nest.
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : synchronous restart to 0 (new tile)
//   en        : advance by one this cycle
//   max_val   : last value before wrapping back to 0
//   cnt       : current count (registered)
//   last      : cnt is at max_val
//   wrap      : counter wraps this cycle (carry into the next loop level)
//   last_nxt  : cnt will be at max_val after this cycle
module sch_loop_cnt
    import sch_addr_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] max_val,
    output logic [CNT_W-1:0] cnt,
    output logic             last,
    output logic             wrap,
    output logic             last_nxt
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + ONE;
        end
    end

    assign last     = (cnt == max_val);
    assign wrap     = en & last;
    // A counter at max with max_val==0 stays "last" after wrapping.
    assign last_nxt = en ? (last ? (max_val == '0) : ((cnt + ONE) == max_val)) : last;

endmodule

// File: rtl/sch_addr_gen.sv
// Scheduler address generator: walks one conv tile and emits feature-buffer,
// weight-buffer and lane-mask read beats to the PE array.
// Loop nest (outer to inner): row group g, channel group c, ky, kx.
//   clk, rst         : clock, asynchronous active-high reset
//   tile_start       : start pulse, only honoured in IDLE
//   cfg_*            : tile configuration, latched on tile_start
//   rd_vld / rd_rdy  : beat handshake towards the PE array
//   fe_rd_addr       : per-bank feature address, bank r at [r*ADDR_WIDTH +: ADDR_WIDTH]
//   fe_rd_en         : feature bank enables (output rows inside out_h)
//   ic_vld           : channel lane mask (channels inside in_c)
//   wt_rd_addr       : weight address
//   kx               : column shift for the PE mux
//   row_last         : last beat of the current row group
//   tile_busy        : high from tile start through the DONE cycle
//   tile_done        : one-cycle completion pulse
module sch_addr_gen
    import sch_addr_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DIM_WIDTH  = 15,
    parameter int KS_WIDTH   = 4,
    parameter int ROW_NUM    = 4,
    parameter int IC_PAR     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           tile_start,
    input  logic [KS_WIDTH-1:0]            cfg_ksize,
    input  logic                           cfg_stride2,
    input  logic [DIM_WIDTH-1:0]           cfg_in_h,
    input  logic [DIM_WIDTH-1:0]           cfg_out_h,
    input  logic [DIM_WIDTH-1:0]           cfg_in_c,
    input  logic [ADDR_WIDTH-1:0]          cfg_fe_base,
    input  logic [ADDR_WIDTH-1:0]          cfg_wt_base,
    output logic                           rd_vld,
    input  logic                           rd_rdy,
    output logic [ROW_NUM*ADDR_WIDTH-1:0]  fe_rd_addr,
    output logic [ROW_NUM-1:0]             fe_rd_en,
    output logic [IC_PAR-1:0]              ic_vld,
    output logic [ADDR_WIDTH-1:0]          wt_rd_addr,
    output logic [KS_WIDTH-1:0]            kx,
    output logic                           row_last,
    output logic                           tile_busy,
    output logic                           tile_done
);

    localparam int AW    = ADDR_WIDTH;
    localparam int CNT_W = DIM_WIDTH + 1;
    localparam int IW    = CNT_W + 1;

    state_t                state_q;

    // Latched tile configuration
    logic [DIM_WIDTH-1:0]  in_h_q;
    logic [DIM_WIDTH-1:0]  out_h_q;
    logic [DIM_WIDTH-1:0]  in_c_q;
    logic                  stride2_q;
    logic [AW-1:0]         fe_base_q;
    logic [AW-1:0]         wt_base_q;
    logic [KS_WIDTH-1:0]   kmax_q;
    logic [CNT_W-1:0]      cmax_q;
    logic [CNT_W-1:0]      gmax_q;

    // Incremental address / mask bookkeeping
    logic [AW-1:0]         chan_base_q;   // c*in_h (mod 2^AW)
    logic [CNT_W-1:0]      ch_idx_q;      // c*IC_PAR
    logic [CNT_W-1:0]      row_idx_q;     // g*ROW_NUM
    logic [CNT_W-1:0]      ch_idx_nxt;
    logic [CNT_W-1:0]      row_idx_nxt;
    logic [AW-1:0]         addr_delta;
    logic [AW-1:0]         row_step;

    // Configuration decode from the cfg pins (used at tile_start)
    logic [CNT_W-1:0]      c_groups_cfg;
    logic [CNT_W-1:0]      g_groups_cfg;
    logic [CNT_W-1:0]      cmax_cfg;
    logic [CNT_W-1:0]      gmax_cfg;
    logic                  degenerate_cfg;

    // Loop counters
    logic                  adv;
    logic                  start_ok;
    logic                  final_beat;
    logic [KS_WIDTH-1:0]   kx_cnt;
    logic [KS_WIDTH-1:0]   ky_cnt;
    logic [CNT_W-1:0]      c_cnt;
    logic [CNT_W-1:0]      g_cnt;
    logic                  kx_last, ky_last, c_last, g_last;
    logic                  kx_wrap, ky_wrap, c_wrap, g_wrap;
    logic                  kx_lnxt, ky_lnxt, c_lnxt, g_lnxt;

    function automatic logic lane_on(input logic [IW-1:0] idx, input logic [DIM_WIDTH-1:0] lim);
        return idx < {2'b00, lim};
    endfunction

    assign c_groups_cfg   = (CNT_W'(cfg_in_c) + CNT_W'(IC_PAR - 1)) / CNT_W'(IC_PAR);
    assign g_groups_cfg   = (CNT_W'(cfg_out_h) + CNT_W'(ROW_NUM - 1)) / CNT_W'(ROW_NUM);
    assign cmax_cfg       = c_groups_cfg - CNT_W'(1);
    assign gmax_cfg       = g_groups_cfg - CNT_W'(1);
    assign degenerate_cfg = (cfg_ksize == '0) || (cfg_out_h == '0) || (cfg_in_c == '0);

    assign start_ok   = (state_q == ST_IDLE) && tile_start;
    assign adv        = (state_q == ST_RUN) && rd_vld && rd_rdy;
    assign final_beat = g_wrap;

    sch_loop_cnt #(.CNT_W(KS_WIDTH)) u_kx (
        .clk(clk), .rst(rst), .clr(start_ok), .en(adv), .max_val(kmax_q),
        .cnt(kx_cnt), .last(kx_last), .wrap(kx_wrap), .last_nxt(kx_lnxt)
    );

    sch_loop_cnt #(.CNT_W(KS_WIDTH)) u_ky (
        .clk(clk), .rst(rst), .clr(start_ok), .en(kx_wrap), .max_val(kmax_q),
        .cnt(ky_cnt), .last(ky_last), .wrap(ky_wrap), .last_nxt(ky_lnxt)
    );

    sch_loop_cnt #(.CNT_W(CNT_W)) u_c (
        .clk(clk), .rst(rst), .clr(start_ok), .en(ky_wrap), .max_val(cmax_q),
        .cnt(c_cnt), .last(c_last), .wrap(c_wrap), .last_nxt(c_lnxt)
    );

    sch_loop_cnt #(.CNT_W(CNT_W)) u_g (
        .clk(clk), .rst(rst), .clr(start_ok), .en(c_wrap), .max_val(gmax_q),
        .cnt(g_cnt), .last(g_last), .wrap(g_wrap), .last_nxt(g_lnxt)
    );

    assign kx = kx_cnt;

    // Counter values and flags not needed by the datapath; kept for visibility.
    logic cnt_unused;
    assign cnt_unused = ^{c_cnt, g_cnt, kx_last, ky_last, g_last, g_lnxt, fe_base_q};

    assign row_step    = AW'(stride_scale(32'(ROW_NUM), stride2_q));
    assign ch_idx_nxt  = c_last ? '0 : ch_idx_q + CNT_W'(IC_PAR);
    assign row_idx_nxt = row_idx_q + CNT_W'(ROW_NUM);

    // Every bank moves by the same amount per beat:
    //   kx step only        : 0
    //   ky step             : +1
    //   channel-group step  : +in_h, undoing the ky excursion (ky is at max)
    //   row-group step      : +ROW_NUM*s, undoing channel and ky excursions
    always_comb begin
        addr_delta = '0;
        if (c_wrap) begin
            addr_delta = row_step - chan_base_q - AW'(ky_cnt);
        end else if (ky_wrap) begin
            addr_delta = AW'(in_h_q) - AW'(ky_cnt);
        end else if (kx_wrap) begin
            addr_delta = AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_h_q      <= '0;
            out_h_q     <= '0;
            in_c_q      <= '0;
            stride2_q   <= 1'b0;
            fe_base_q   <= '0;
            wt_base_q   <= '0;
            kmax_q      <= '0;
            cmax_q      <= '0;
            gmax_q      <= '0;
            chan_base_q <= '0;
            ch_idx_q    <= '0;
            row_idx_q   <= '0;
            rd_vld      <= 1'b0;
            fe_rd_addr  <= '0;
            fe_rd_en    <= '0;
            ic_vld      <= '0;
            wt_rd_addr  <= '0;
            row_last    <= 1'b0;
            tile_busy   <= 1'b0;
            tile_done   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tile_start) begin
                        in_h_q    <= cfg_in_h;
                        out_h_q   <= cfg_out_h;
                        in_c_q    <= cfg_in_c;
                        stride2_q <= cfg_stride2;
                        fe_base_q <= cfg_fe_base;
                        wt_base_q <= cfg_wt_base;
                        kmax_q    <= cfg_ksize - KS_WIDTH'(1);
                        cmax_q    <= cmax_cfg;
                        gmax_q    <= gmax_cfg;
                        tile_busy <= 1'b1;
                        if (degenerate_cfg) begin
                            state_q   <= ST_DONE;
                            tile_done <= 1'b1;
                        end else begin
                            // Present beat 0 (g=c=ky=kx=0) on the next cycle.
                            state_q     <= ST_RUN;
                            rd_vld      <= 1'b1;
                            chan_base_q <= '0;
                            ch_idx_q    <= '0;
                            row_idx_q   <= '0;
                            wt_rd_addr  <= cfg_wt_base;
                            row_last    <= (cfg_ksize == KS_WIDTH'(1)) && (cmax_cfg == '0);
                            for (int r = 0; r < ROW_NUM; r++) begin
                                fe_rd_addr[r*AW +: AW] <= cfg_fe_base
                                                        + AW'(stride_scale(32'(r), cfg_stride2));
                                fe_rd_en[r] <= lane_on(IW'(r), cfg_out_h);
                            end
                            for (int i = 0; i < IC_PAR; i++) begin
                                ic_vld[i] <= lane_on(IW'(i), cfg_in_c);
                            end
                        end
                    end
                end

                ST_RUN: begin
                    if (adv) begin
                        if (final_beat) begin
                            state_q   <= ST_DONE;
                            rd_vld    <= 1'b0;
                            tile_done <= 1'b1;
                        end else begin
                            for (int r = 0; r < ROW_NUM; r++) begin
                                fe_rd_addr[r*AW +: AW] <= fe_rd_addr[r*AW +: AW] + addr_delta;
                            end
                            wt_rd_addr <= c_wrap ? wt_base_q : wt_rd_addr + AW'(1);
                            row_last   <= kx_lnxt & ky_lnxt & c_lnxt;
                            if (ky_wrap) begin
                                chan_base_q <= c_last ? '0 : chan_base_q + AW'(in_h_q);
                                ch_idx_q    <= ch_idx_nxt;
                                for (int i = 0; i < IC_PAR; i++) begin
                                    ic_vld[i] <= lane_on(IW'(ch_idx_nxt) + IW'(i), in_c_q);
                                end
                            end
                            if (c_wrap) begin
                                row_idx_q <= row_idx_nxt;
                                for (int r = 0; r < ROW_NUM; r++) begin
                                    fe_rd_en[r] <= lane_on(IW'(row_idx_nxt) + IW'(r), out_h_q);
                                end
                            end
                        end
                    end
                end

                ST_DONE: begin
                    state_q   <= ST_IDLE;
                    tile_done <= 1'b0;
                    tile_busy <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sch_addr_gen.sv
// Directed bench for sch_addr_gen: table of tile configs with hand-derived
// expectations, a per-beat reference model, plus backpressure and
// reset/retrigger sequences.
module tb_sch_addr_gen;

    localparam int AW = 10;
    localparam int DW = 15;
    localparam int KW = 4;
    localparam int RN = 4;
    localparam int IP = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              tile_start;
    logic [KW-1:0]     cfg_ksize;
    logic              cfg_stride2;
    logic [DW-1:0]     cfg_in_h;
    logic [DW-1:0]     cfg_out_h;
    logic [DW-1:0]     cfg_in_c;
    logic [AW-1:0]     cfg_fe_base;
    logic [AW-1:0]     cfg_wt_base;
    logic              rd_vld;
    logic              rd_rdy;
    logic [RN*AW-1:0]  fe_rd_addr;
    logic [RN-1:0]     fe_rd_en;
    logic [IP-1:0]     ic_vld;
    logic [AW-1:0]     wt_rd_addr;
    logic [KW-1:0]     kx;
    logic              row_last;
    logic              tile_busy;
    logic              tile_done;

    always #5 clk = ~clk;

    sch_addr_gen dut (
        .clk(clk), .rst(rst), .tile_start(tile_start),
        .cfg_ksize(cfg_ksize), .cfg_stride2(cfg_stride2),
        .cfg_in_h(cfg_in_h), .cfg_out_h(cfg_out_h), .cfg_in_c(cfg_in_c),
        .cfg_fe_base(cfg_fe_base), .cfg_wt_base(cfg_wt_base),
        .rd_vld(rd_vld), .rd_rdy(rd_rdy),
        .fe_rd_addr(fe_rd_addr), .fe_rd_en(fe_rd_en), .ic_vld(ic_vld),
        .wt_rd_addr(wt_rd_addr), .kx(kx), .row_last(row_last),
        .tile_busy(tile_busy), .tile_done(tile_done)
    );

    typedef struct {
        int          k;
        bit          s2;
        int          in_h;
        int          out_h;
        int          in_c;
        int          fe_base;
        int          wt_base;
        int          exp_beats;
        int          probe;       // beat index whose addresses are hand-checked, -1 none
        logic [39:0] probe_addr;  // {bank3, bank2, bank1, bank0}
        logic [3:0]  first_en;
        logic [3:0]  first_ic;
    } vec_t;

    vec_t        tbl [7];
    int          tests = 0;
    int          fails = 0;
    logic [62:0] obs;

    assign obs = {fe_rd_addr, fe_rd_en, ic_vld, wt_rd_addr, kx, row_last};

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Reference: decompose the beat index directly and evaluate the closed-form equations.
    function automatic logic [62:0] model(input vec_t v, input int n);
        int kk, cg, kxi, kyi, ci, gi, s;
        logic [39:0] a;
        logic [3:0]  en, ic;
        logic [9:0]  wt;
        logic        rl;
        s  = v.s2 ? 2 : 1;
        kk = v.k * v.k;
        cg = (v.in_c + 3) / 4;
        if (kk == 0 || cg == 0) return '0;
        kxi = n % v.k;
        kyi = (n / v.k) % v.k;
        ci  = (n / kk) % cg;
        gi  = n / (kk * cg);
        for (int r = 0; r < 4; r++) begin
            a[r*10 +: 10] = 10'((v.fe_base + ci*v.in_h + (gi*4 + r)*s + kyi) % 1024);
            en[r] = (gi*4 + r < v.out_h);
        end
        for (int i = 0; i < 4; i++) ic[i] = (ci*4 + i < v.in_c);
        wt = 10'((v.wt_base + ci*kk + kyi*v.k + kxi) % 1024);
        rl = (ci == cg - 1) && (kyi == v.k - 1) && (kxi == v.k - 1);
        return {a, en, ic, wt, 4'(kxi), rl};
    endfunction

    task automatic apply_cfg(input vec_t v);
        cfg_ksize   = KW'(v.k);
        cfg_stride2 = v.s2;
        cfg_in_h    = DW'(v.in_h);
        cfg_out_h   = DW'(v.out_h);
        cfg_in_c    = DW'(v.in_c);
        cfg_fe_base = AW'(v.fe_base);
        cfg_wt_base = AW'(v.wt_base);
    endtask

    task automatic start_tile(input vec_t v);
        @(negedge clk);
        apply_cfg(v);
        tile_start = 1'b1;
        @(negedge clk);
        tile_start = 1'b0;
    endtask

    // Runs one tile; rd_rdy is held low for bp_len cycles when beat bp_at is presented.
    task automatic run_tile(input vec_t v, input int bp_at, input int bp_len, input string tag);
        int beats = 0;
        int stall = 0;
        int cyc   = 0;
        start_tile(v);
        while (rd_vld && cyc < 1000) begin
            rd_rdy = (beats == bp_at && stall < bp_len) ? 1'b0 : 1'b1;
            if (!rd_rdy) stall++;
            check({tag, "_beat"}, 64'(obs), 64'(model(v, beats)));
            if (beats == 0 && rd_rdy)
                check({tag, "_first_masks"}, 64'({fe_rd_en, ic_vld}), 64'({v.first_en, v.first_ic}));
            if (beats == v.probe && rd_rdy)
                check({tag, "_probe_addr"}, 64'(fe_rd_addr), 64'(v.probe_addr));
            if (rd_rdy) beats++;
            @(negedge clk);
            cyc++;
        end
        rd_rdy = 1'b1;
        if (cyc >= 1000) check({tag, "_timeout"}, 64'(cyc), 64'(0));
        check({tag, "_beat_count"}, 64'(beats), 64'(v.exp_beats));
        check({tag, "_done_pulse"}, 64'({tile_done, tile_busy, rd_vld}), 64'(3'b110));
        @(negedge clk);
        check({tag, "_done_clear"}, 64'({tile_done, tile_busy, rd_vld}), 64'(3'b000));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            k  s2 in_h out_h in_c fe    wt  beats probe probe_addr                          en       ic
        tbl[0] = '{3, 0, 11, 9, 9, 0,    0,  81, 51, {10'd31, 10'd30, 10'd29, 10'd28},     4'b1111, 4'b1111};
        tbl[1] = '{3, 1, 9,  4, 4, 0,    0,  9,  6,  {10'd8, 10'd6, 10'd4, 10'd2},         4'b1111, 4'b1111};
        tbl[2] = '{1, 0, 4,  4, 4, 1022, 0,  1,  0,  {10'd1, 10'd0, 10'd1023, 10'd1022},   4'b1111, 4'b1111};
        tbl[3] = '{3, 0, 11, 9, 0, 0,    0,  0,  -1, 40'd0,                                4'b0000, 4'b0000};
        tbl[4] = '{0, 0, 11, 9, 9, 0,    0,  0,  -1, 40'd0,                                4'b0000, 4'b0000};
        tbl[5] = '{3, 0, 11, 0, 9, 0,    0,  0,  -1, 40'd0,                                4'b0000, 4'b0000};
        tbl[6] = '{2, 0, 5,  3, 2, 100,  50, 4,  3,  {10'd104, 10'd103, 10'd102, 10'd101}, 4'b0111, 4'b0011};

        rst        = 1'b1;
        tile_start = 1'b0;
        rd_rdy     = 1'b1;
        apply_cfg(tbl[3]);
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({obs, rd_vld, tile_busy, tile_done}), 64'(0));
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_tile(tbl[i], -1, 0, $sformatf("vec%0d", i));
        end

        // Backpressure mid-tile: beat 30 must stay frozen for 5 stalled cycles.
        run_tile(tbl[0], 30, 5, "bp");

        // Retrigger while busy is ignored; async reset aborts mid-tile.
        start_tile(tbl[0]);
        rd_rdy = 1'b1;
        for (int n = 0; n < 5; n++) @(negedge clk);
        apply_cfg(tbl[3]);
        tile_start = 1'b1;
        check("busy_beat5", 64'(obs), 64'(model(tbl[0], 5)));
        @(negedge clk);
        tile_start = 1'b0;
        check("ignored_start_beat6", 64'(obs), 64'(model(tbl[0], 6)));
        check("ignored_start_ctl", 64'({rd_vld, tile_busy, tile_done}), 64'(3'b110));
        for (int n = 6; n < 40; n++) @(negedge clk);
        check("beat40", 64'(obs), 64'(model(tbl[0], 40)));
        #2 rst = 1'b1;
        #1 check("async_reset", 64'({obs, rd_vld, tile_busy, tile_done}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("no_done_after_abort", 64'({tile_done, tile_busy, rd_vld}), 64'(0));
        end
        run_tile(tbl[0], -1, 0, "restart");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sch_addr_gen.md
Name: sch_addr_gen

Overview:
- Parametrised successor to the scheduler address interface: generates feature-buffer, weight-buffer and lane-mask read beats for one conv tile.
- Sits between the tile controller (tile start/config) and the PE array (valid/ready beats).
- Generalised over bank count, IC parallelism and address width.
- Adds stride-2 mode, partial row/channel masking and backpressure.

Parameters:
ADDR_WIDTH, 10, buffer address width (addresses wrap modulo 2^ADDR_WIDTH)
DIM_WIDTH, 15, width of tile dimension fields
KS_WIDTH, 4, kernel size field width
ROW_NUM, 4, feature banks / output rows produced in parallel
IC_PAR, 4, input channels per beat

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
tile_start  in  1  one-cycle start pulse; sampled only in IDLE
cfg_ksize  in  KS_WIDTH  kernel size k
cfg_stride2  in  1  0: stride 1, 1: stride 2
cfg_in_h  in  DIM_WIDTH  input rows per channel group in buffer
cfg_out_h  in  DIM_WIDTH  output rows of tile
cfg_in_c  in  DIM_WIDTH  input channels
cfg_fe_base  in  ADDR_WIDTH  feature buffer base
cfg_wt_base  in  ADDR_WIDTH  weight buffer base
rd_vld  out  1  beat valid
rd_rdy  in  1  PE ready
fe_rd_addr  out  ROW_NUM*ADDR_WIDTH  per-bank address, bank r at [r*ADDR_WIDTH +: ADDR_WIDTH]
fe_rd_en  out  ROW_NUM  bank enable mask
ic_vld  out  IC_PAR  channel lane mask
wt_rd_addr  out  ADDR_WIDTH  weight address
kx  out  KS_WIDTH  column shift for PE mux
row_last  out  1  beat is last of its row group
tile_busy  out  1  state != IDLE
tile_done  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE; all outputs 0; counters and latched config 0. Asserting rst mid-tile aborts immediately with no tile_done.
- States:
  - IDLE: on tile_start, latch all cfg_*.
    - If k==0, out_h==0 or in_c==0: go to DONE.
    - Otherwise go to RUN.
  - RUN: on the final handshake, go to DONE.
  - DONE: exactly one cycle with tile_done=1, then IDLE.
  - tile_start is ignored outside IDLE.
- Beat timing:
  - First rd_vld is the cycle after tile_start.
  - A beat completes on rd_vld & rd_rdy. All beat outputs are registered and held stable while rd_vld & !rd_rdy.
  - The next beat is presented the following cycle, so the rate is 1 beat/cycle under rd_rdy=1.
- Loop order, outer to inner:
  - row group g in 0..ceil(out_h/ROW_NUM)-1
  - channel group c in 0..ceil(in_c/IC_PAR)-1
  - ky in 0..k-1
  - kx in 0..k-1
  - Total beats = G*C*k*k.
- Feature addresses:
  - s = 1 or 2 per cfg_stride2.
  - fe_rd_addr[r] = fe_base + c*in_h + (g*ROW_NUM + r)*s + ky, mod 2^ADDR_WIDTH.
  - Computed incrementally with no multipliers:
    - chan_base accumulates in_h.
    - row_base accumulates ROW_NUM*s.
    - r*s is constant.
- Weight address: wt_rd_addr = wt_base + (c*k*k + ky*k + kx). Increments by 1 per beat and reloads wt_base at each new row group.
- Masks:
  - fe_rd_en[r] = (g*ROW_NUM + r < out_h).
  - ic_vld[i] = (c*IC_PAR + i < in_c).
- row_last: 1 when c, ky, kx are all at their maxima.
- tile_busy = state != IDLE, including the DONE cycle.
- Internal counters use DIM_WIDTH+1 bits; no overflow for legal configs.

Decomposition:
- Package sch_addr_pkg: state enum (IDLE, RUN, DONE), state width, stride-decode helper function.
- Sub-module sch_loop_cnt: wrapping counter with enable, programmable max, and wrap/last output. Instantiated four times, chained for kx, ky, c and g.

Test Plan:
1. Baseline, rd_rdy=1: ROW_NUM=4, IC_PAR=4, k=3, stride1, in_h=11, out_h=9, in_c=9, bases 0.
   - Exactly 81 beats; tile_done one cycle after the 81st.
   - First beat fe_rd_addr = {3,2,1,0}.
   - Beat (g=1,c=2,ky=2,kx=0): bank0 = 28.
   - g=2 beats: fe_rd_en = 4'b0001.
   - c=2 beats: ic_vld = 4'b0001.
   - wt_rd_addr runs 0..26 per row group.
2. Stride 2: k=3, in_h=9, out_h=4, in_c=4.
   - Beat ky=2: fe_rd_addr = {8,6,4,2}.
   - 9 beats total, row_last on the 9th only.
3. Backpressure: baseline config, rd_rdy low for 5 cycles mid-tile.
   - All beat outputs frozen.
   - No beat skipped or duplicated; count is still 81.
4. Degenerate: in_c=0.
   - No rd_vld.
   - tile_done high the cycle after tile_start, then tile_busy low.
5. Wrap: fe_base=1022, k=1, out_h=4, in_c=4.
   - fe_rd_addr = {1,0,1023,1022}.
6. Reset and retrigger: assert rst during beat 40 of the baseline.
   - All outputs 0 asynchronously; no tile_done.
   - A tile_start pulse while busy is ignored.
   - A new tile after reset restarts at beat 0.
